// File: rtl/gmii_rx_fcs_check_if.sv
// GMII receive bus into the FCS checker and its pass-through/status bus out.
// Master drives e_rx*; slave (the checker) drives the delayed data, frame status and counters.
interface gmii_rx_fcs_check_if;
    logic        e_rxdv;
    logic [7:0]  e_rxd;
    logic        e_rxer;
    logic        o_rxdv;
    logic [7:0]  o_rxd;
    logic        o_sof;
    logic        frame_done;
    logic        frame_ok;
    logic        fcs_err;
    logic        len_err;
    logic        align_err;
    logic        rxer_seen;
    logic [15:0] frame_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    modport master (
        output e_rxdv, e_rxd, e_rxer,
        input  o_rxdv, o_rxd, o_sof, frame_done, frame_ok, fcs_err, len_err,
               align_err, rxer_seen, frame_len, good_cnt, bad_cnt
    );

    modport slave (
        input  e_rxdv, e_rxd, e_rxer,
        output o_rxdv, o_rxd, o_sof, frame_done, frame_ok, fcs_err, len_err,
               align_err, rxer_seen, frame_len, good_cnt, bad_cnt
    );
endinterface

// File: rtl/gmii_rx_fcs_check.sv
// GMII rx pass-through (1 cycle) with preamble/SFD tracking, CRC-32 residue check and frame status.
// No backpressure: GMII cannot stall, every byte is accepted and forwarded unconditionally.
module gmii_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic               e_rxc,
    input  logic               reset_n,
    gmii_rx_fcs_check_if.slave rx
);
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic        rxer_q, rxer_d;
    logic        o_rxdv_q, o_rxdv_d;
    logic [7:0]  o_rxd_q, o_rxd_d;
    logic        o_sof_q, o_sof_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        fcs_err_q, fcs_err_d;
    logic        len_err_q, len_err_d;
    logic        align_err_q, align_err_d;
    logic        rxer_seen_q, rxer_seen_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;
    logic        fin, fin_align, fcs_bad, len_bad, frame_good;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | ~rx.e_rxdv;
        crc_d       = crc_q;
        len_d       = len_q;
        rxer_d      = rxer_q;
        o_rxdv_d    = rx.e_rxdv;
        o_rxd_d     = rx.e_rxd;
        o_sof_d     = (state_q == DATA) && rx.e_rxdv && (len_q == 16'd0);
        done_d      = 1'b0;
        ok_d        = ok_q;
        fcs_err_d   = fcs_err_q;
        len_err_d   = len_err_q;
        align_err_d = align_err_q;
        rxer_seen_d = rxer_seen_q;
        frame_len_d = frame_len_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        fin         = 1'b0;
        fin_align   = 1'b0;

        case (state_q)
            IDLE: begin
                rxer_d = 1'b0;
                // Only arm once the line has been seen idle, so a frame cut by reset is ignored.
                if (armed_q && rx.e_rxdv) begin
                    if (rx.e_rxd == 8'h55) begin
                        state_d = PRE;
                    end else if (rx.e_rxd == 8'hD5) begin
                        state_d = DATA;
                        crc_d   = CRC_INIT;
                        len_d   = 16'd0;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            PRE: begin
                if (!rx.e_rxdv) begin
                    state_d = IDLE;
                end else begin
                    rxer_d = rxer_q | rx.e_rxer;
                    if (rx.e_rxd == 8'hD5) begin
                        state_d = DATA;
                        crc_d   = CRC_INIT;
                        len_d   = 16'd0;
                    end else if (rx.e_rxd != 8'h55) begin
                        state_d = DROP;
                    end
                end
            end
            DATA: begin
                if (rx.e_rxdv) begin
                    rxer_d = rxer_q | rx.e_rxer;
                    crc_d  = crc_byte(crc_q, rx.e_rxd);
                    len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                end else begin
                    state_d = IDLE;
                    fin     = 1'b1;
                end
            end
            default: begin
                if (rx.e_rxdv) begin
                    rxer_d = rxer_q | rx.e_rxer;
                end else begin
                    state_d   = IDLE;
                    fin       = 1'b1;
                    fin_align = 1'b1;
                end
            end
        endcase

        fcs_bad    = !fin_align && (crc_q != CRC_RESIDUE);
        len_bad    = !fin_align && ((len_q < MIN_L) || (len_q > MAX_L));
        frame_good = !(fcs_bad || len_bad || fin_align || rxer_q);

        if (fin) begin
            done_d      = 1'b1;
            fcs_err_d   = fcs_bad;
            len_err_d   = len_bad;
            align_err_d = fin_align;
            rxer_seen_d = rxer_q;
            frame_len_d = fin_align ? 16'd0 : len_q;
            ok_d        = frame_good;
            if (frame_good) begin
                good_cnt_d = (good_cnt_q == 16'hFFFF) ? good_cnt_q : good_cnt_q + 16'd1;
            end else begin
                bad_cnt_d  = (bad_cnt_q == 16'hFFFF) ? bad_cnt_q : bad_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge e_rxc or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            crc_q       <= CRC_INIT;
            len_q       <= 16'd0;
            rxer_q      <= 1'b0;
            o_rxdv_q    <= 1'b0;
            o_rxd_q     <= 8'd0;
            o_sof_q     <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            fcs_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            align_err_q <= 1'b0;
            rxer_seen_q <= 1'b0;
            frame_len_q <= 16'd0;
            good_cnt_q  <= 16'd0;
            bad_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            rxer_q      <= rxer_d;
            o_rxdv_q    <= o_rxdv_d;
            o_rxd_q     <= o_rxd_d;
            o_sof_q     <= o_sof_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            fcs_err_q   <= fcs_err_d;
            len_err_q   <= len_err_d;
            align_err_q <= align_err_d;
            rxer_seen_q <= rxer_seen_d;
            frame_len_q <= frame_len_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign rx.o_rxdv     = o_rxdv_q;
    assign rx.o_rxd      = o_rxd_q;
    assign rx.o_sof      = o_sof_q;
    assign rx.frame_done = done_q;
    assign rx.frame_ok   = ok_q;
    assign rx.fcs_err    = fcs_err_q;
    assign rx.len_err    = len_err_q;
    assign rx.align_err  = align_err_q;
    assign rx.rxer_seen  = rxer_seen_q;
    assign rx.frame_len  = frame_len_q;
    assign rx.good_cnt   = good_cnt_q;
    assign rx.bad_cnt    = bad_cnt_q;
endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check: builds frames with known FCS and checks status, counters and timing.
module tb_gmii_rx_fcs_check;
    logic e_rxc = 1'b0;
    logic reset_n = 1'b0;
    always #4 e_rxc = ~e_rxc;

    gmii_rx_fcs_check_if bus ();

    gmii_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .e_rxc   (e_rxc),
        .reset_n (reset_n),
        .rx      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-end observations, one entry per frame_done pulse.
    bit   q_ok[$], q_fcs[$], q_lenerr[$], q_align[$], q_rxer[$], q_fell[$];
    int   q_len[$];
    int   done_cnt = 0;
    int   sof_cnt  = 0;
    logic [7:0] sof_byte = 8'h00;
    logic [7:0] prev_rxd = 8'h00;
    logic prev_rxdv = 1'b0;
    logic last_ordv = 1'b0;
    bit   pt_en = 1'b0;

    always @(negedge e_rxc) begin
        if (pt_en) begin
            check("o_rxd_delay", {24'h0, bus.o_rxd}, {24'h0, prev_rxd});
            check("o_rxdv_delay", {31'h0, bus.o_rxdv}, {31'h0, prev_rxdv});
        end
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            q_ok.push_back(bus.frame_ok);
            q_fcs.push_back(bus.fcs_err);
            q_lenerr.push_back(bus.len_err);
            q_align.push_back(bus.align_err);
            q_rxer.push_back(bus.rxer_seen);
            q_len.push_back(int'(bus.frame_len));
            q_fell.push_back(last_ordv && !bus.o_rxdv);
        end
        if (bus.o_sof === 1'b1) begin
            sof_cnt++;
            sof_byte = bus.o_rxd;
        end
        prev_rxd  = bus.e_rxd;
        prev_rxdv = bus.e_rxdv;
        last_ordv = bus.o_rxdv;
    end

    logic [7:0] frm[$];
    int er_idx = -1;

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(posedge e_rxc);
        #2;
        bus.e_rxdv = dv;
        bus.e_rxd  = d;
        bus.e_rxer = er;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], (i == er_idx));
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // flen counts DA..FCS; body byte i is (i*37+11) mod 256, so the first DA byte is 8'h0B.
    task automatic build(input int flen, input bit flip);
        logic [31:0] c, fcs;
        logic [7:0] b;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < flen - 4; i++) begin
            b = 8'((i * 37 + 11) & 255);
            frm.push_back(b);
            c = crc_upd(c, b);
        end
        fcs = ~c;
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        if (flip) frm[18] = frm[18] ^ 8'h04;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_o_rxdv"},     {31'h0, bus.o_rxdv},     32'h0);
        check({pfx, "_o_rxd"},      {24'h0, bus.o_rxd},      32'h0);
        check({pfx, "_o_sof"},      {31'h0, bus.o_sof},      32'h0);
        check({pfx, "_frame_done"}, {31'h0, bus.frame_done}, 32'h0);
        check({pfx, "_frame_ok"},   {31'h0, bus.frame_ok},   32'h0);
        check({pfx, "_fcs_err"},    {31'h0, bus.fcs_err},    32'h0);
        check({pfx, "_len_err"},    {31'h0, bus.len_err},    32'h0);
        check({pfx, "_align_err"},  {31'h0, bus.align_err},  32'h0);
        check({pfx, "_rxer_seen"},  {31'h0, bus.rxer_seen},  32'h0);
        check({pfx, "_frame_len"},  {16'h0, bus.frame_len},  32'h0);
        check({pfx, "_good_cnt"},   {16'h0, bus.good_cnt},   32'h0);
        check({pfx, "_bad_cnt"},    {16'h0, bus.bad_cnt},    32'h0);
    endtask

    int d0, n;

    initial begin
        bus.e_rxdv = 1'b0;
        bus.e_rxd  = 8'h00;
        bus.e_rxer = 1'b0;
        repeat (3) @(posedge e_rxc);
        @(negedge e_rxc);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        repeat (3) drive(1'b0, 8'h00, 1'b0);

        // Good 64-byte frame with pass-through and SOF checked
        build(64, 1'b0);
        d0 = done_cnt;
        pt_en = 1'b1;
        send_frame(4);
        pt_en = 1'b0;
        n = q_ok.size() - 1;
        check("good_done_cnt", done_cnt - d0, 1);
        check("good_frame_ok", {31'h0, q_ok[n]}, 1);
        check("good_fcs_err", {31'h0, q_fcs[n]}, 0);
        check("good_frame_len", q_len[n], 64);
        check("good_done_at_rxdv_fall", {31'h0, q_fell[n]}, 1);
        check("good_good_cnt", {16'h0, bus.good_cnt}, 1);
        check("good_bad_cnt", {16'h0, bus.bad_cnt}, 0);
        check("good_sof_cnt", sof_cnt, 1);
        check("good_sof_byte", {24'h0, sof_byte}, 32'h0B);

        // Same frame with one payload bit flipped
        build(64, 1'b1);
        send_frame(4);
        n = q_ok.size() - 1;
        check("flip_fcs_err", {31'h0, q_fcs[n]}, 1);
        check("flip_frame_ok", {31'h0, q_ok[n]}, 0);
        check("flip_bad_cnt", {16'h0, bus.bad_cnt}, 1);
        check("flip_good_cnt", {16'h0, bus.good_cnt}, 1);

        // Runt and giant frames with valid FCS
        build(63, 1'b0);
        send_frame(4);
        n = q_ok.size() - 1;
        check("runt_len_err", {31'h0, q_lenerr[n]}, 1);
        check("runt_fcs_err", {31'h0, q_fcs[n]}, 0);
        check("runt_frame_len", q_len[n], 63);
        build(1519, 1'b0);
        send_frame(4);
        n = q_ok.size() - 1;
        check("giant_len_err", {31'h0, q_lenerr[n]}, 1);
        check("giant_fcs_err", {31'h0, q_fcs[n]}, 0);
        check("giant_frame_len", q_len[n], 1519);
        check("giant_bad_cnt", {16'h0, bus.bad_cnt}, 3);

        // "123456789" with its well-known CRC-32 0xCBF43926 sent LSB byte first
        frm = '{8'h55, 8'h55, 8'hD5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(4);
        n = q_ok.size() - 1;
        check("check9_fcs_err", {31'h0, q_fcs[n]}, 0);
        check("check9_len_err", {31'h0, q_lenerr[n]}, 1);
        check("check9_frame_len", q_len[n], 13);

        // Illegal byte in preamble
        frm = '{8'h55, 8'h55};
        repeat (18) frm.push_back(8'h12);
        send_frame(4);
        n = q_ok.size() - 1;
        check("align_align_err", {31'h0, q_align[n]}, 1);
        check("align_frame_len", q_len[n], 0);
        check("align_fcs_err", {31'h0, q_fcs[n]}, 0);
        check("align_len_err", {31'h0, q_lenerr[n]}, 0);
        check("align_frame_ok", {31'h0, q_ok[n]}, 0);
        check("align_bad_cnt", {16'h0, bus.bad_cnt}, 5);

        // Preamble abandoned before SFD
        frm = '{8'h55, 8'h55, 8'h55};
        d0 = done_cnt;
        send_frame(4);
        check("nosfd_no_done", done_cnt - d0, 0);
        check("nosfd_bad_cnt", {16'h0, bus.bad_cnt}, 5);
        check("nosfd_good_cnt", {16'h0, bus.good_cnt}, 1);
        check("nosfd_status_held", {31'h0, bus.align_err}, 1);

        // rxer mid-payload, then a back-to-back good frame after a 1-cycle gap
        d0 = done_cnt;
        build(64, 1'b0);
        er_idx = 30;
        send_frame(1);
        er_idx = -1;
        send_frame(4);
        n = q_ok.size() - 1;
        check("b2b_done_cnt", done_cnt - d0, 2);
        check("rxer_rxer_seen", {31'h0, q_rxer[n-1]}, 1);
        check("rxer_frame_ok", {31'h0, q_ok[n-1]}, 0);
        check("rxer_fcs_err", {31'h0, q_fcs[n-1]}, 0);
        check("b2b_frame_ok", {31'h0, q_ok[n]}, 1);
        check("b2b_rxer_seen", {31'h0, q_rxer[n]}, 0);
        check("b2b_good_cnt", {16'h0, bus.good_cnt}, 2);
        check("b2b_bad_cnt", {16'h0, bus.bad_cnt}, 6);

        // Reset mid-DATA; rxdv stays high across the release
        build(64, 1'b0);
        d0 = done_cnt;
        for (int i = 0; i < 20; i++) drive(1'b1, frm[i], 1'b0);
        @(negedge e_rxc);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        for (int i = 20; i < frm.size(); i++) begin
            drive(1'b1, frm[i], 1'b0);
            if (i == 23) reset_n = 1'b1;
        end
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_good_cnt", {16'h0, bus.good_cnt}, 0);
        check("midrst_bad_cnt", {16'h0, bus.bad_cnt}, 0);
        send_frame(4);
        check("post_rst_good_cnt", {16'h0, bus.good_cnt}, 1);
        check("post_rst_frame_ok", {31'h0, bus.frame_ok}, 1);

        // Bad-counter saturation, preloaded just below the ceiling
        @(negedge e_rxc);
        force dut.bad_cnt_q = 16'hFFFD;
        #1;
        release dut.bad_cnt_q;
        check("sat_preload", {16'h0, bus.bad_cnt}, 32'hFFFD);
        frm = '{8'h00};
        d0 = done_cnt;
        send_frame(3);
        check("sat_step1", {16'h0, bus.bad_cnt}, 32'hFFFE);
        repeat (3) send_frame(1);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("sat_done_cnt", done_cnt - d0, 4);
        check("sat_hold", {16'h0, bus.bad_cnt}, 32'hFFFF);
        check("sat_good_cnt", {16'h0, bus.good_cnt}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
